// File: rtl/mux_n_1_scan.sv
// Registered N:1 multiplexer with manual select, auto-scan, post-switch blanking
// and an all-channel XOR mode.
module mux_n_1_scan #(
    parameter int unsigned CH           = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned SCAN_CYCLES  = 8,
    parameter int unsigned BLANK_CYCLES = 2,
    localparam int unsigned SEL_W       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [CH*WIDTH-1:0]   data_in,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  scan_en,
    input  logic                  xor_mode,
    output logic [WIDTH-1:0]      data_out,
    output logic [SEL_W-1:0]      ch_out,
    output logic                  ch_valid
);

    localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [SEL_W:0]   NumCh     = (SEL_W + 1)'(CH);
    localparam logic [SEL_W-1:0] LastCh    = SEL_W'(CH - 1);
    localparam logic [CNT_W-1:0] ScanLast  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [BLK_W-1:0] BlankLoad =
        BLK_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    if (CH < 2 || SCAN_CYCLES <= BLANK_CYCLES) begin : g_param_check
        $error("mux_n_1_scan: need CH >= 2 and SCAN_CYCLES > BLANK_CYCLES");
    end

    typedef enum logic {StRun, StBlank} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_ch_q, nxt;
    logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [BLK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               change;
    logic [WIDTH-1:0]   chans [CH];
    logic [WIDTH-1:0]   xor_all;

    // Unpack the channel bus and fold all channels into one XOR word.
    always_comb begin
        xor_all = '0;
        for (int k = 0; k < int'(CH); k++) begin
            chans[k] = data_in[k*WIDTH +: WIDTH];
            xor_all  = xor_all ^ chans[k];
        end
    end

    // Next-channel selection: scan counter in auto mode, range-checked sel in manual.
    always_comb begin
        nxt        = cur_ch_q;
        scan_cnt_d = '0;
        if (scan_en) begin
            if (scan_cnt_q == ScanLast) begin
                scan_cnt_d = '0;
                nxt        = (cur_ch_q == LastCh) ? '0 : cur_ch_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end else if ({1'b0, sel} < NumCh) begin
            nxt = sel;
        end
    end

    assign change = (nxt != cur_ch_q);

    // FSM next state and registered output data; XOR mode overrides blanking.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        data_d      = '0;
        valid_d     = 1'b0;
        if (xor_mode) begin
            state_d     = StRun;
            blank_cnt_d = '0;
            data_d      = xor_all;
            valid_d     = 1'b1;
        end else if (change && (BLANK_CYCLES > 0)) begin
            // Entering or restarting blanking; the load edge counts as one blank cycle.
            state_d     = StBlank;
            blank_cnt_d = BlankLoad;
        end else begin
            unique case (state_q)
                StRun: begin
                    data_d  = chans[nxt];
                    valid_d = 1'b1;
                end
                StBlank: begin
                    if (blank_cnt_q == '0) begin
                        state_d = StRun;
                        data_d  = chans[nxt];
                        valid_d = 1'b1;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 1'b1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StRun;
            cur_ch_q    <= '0;
            scan_cnt_q  <= '0;
            blank_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= nxt;
            scan_cnt_q  <= scan_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign data_out = data_q;
    assign ch_out   = cur_ch_q;
    assign ch_valid = valid_q;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Self-checking bench for mux_n_1_scan: vector table driven through a scoreboard,
// plus a second CH=5 instance for out-of-range manual selects.
module tb_mux_n_1_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: CH=4, WIDTH=8, SCAN=8, BLANK=2
    logic        rst;
    logic [31:0] data_in;
    logic [1:0]  sel;
    logic        scan_en;
    logic        xor_mode;
    logic [7:0]  data_out;
    logic [1:0]  ch_out;
    logic        ch_valid;

    mux_n_1_scan #(
        .CH(4), .WIDTH(8), .SCAN_CYCLES(8), .BLANK_CYCLES(2)
    ) u_dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .data_in  (data_in),
        .sel      (sel),
        .scan_en  (scan_en),
        .xor_mode (xor_mode),
        .data_out (data_out),
        .ch_out   (ch_out),
        .ch_valid (ch_valid)
    );

    // Second DUT: CH=5 so sel can be out of range
    logic        rst5;
    logic [39:0] data_in5;
    logic [2:0]  sel5;
    logic        scan_en5;
    logic        xor_mode5;
    logic [7:0]  data_out5;
    logic [2:0]  ch_out5;
    logic        ch_valid5;

    mux_n_1_scan #(
        .CH(5), .WIDTH(8), .SCAN_CYCLES(8), .BLANK_CYCLES(2)
    ) u_dut5 (
        .sys_clk  (clk),
        .sys_rst  (rst5),
        .data_in  (data_in5),
        .sel      (sel5),
        .scan_en  (scan_en5),
        .xor_mode (xor_mode5),
        .data_out (data_out5),
        .ch_out   (ch_out5),
        .ch_valid (ch_valid5)
    );

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic       scan;
        logic       xm;
        logic [7:0] ch3;
        logic [7:0] d;
        logic       v;
        logic [1:0] ch;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [1:0] ch;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input logic r, input logic [1:0] s, input logic sc,
                                input logic x, input logic [7:0] c3, input logic [7:0] d,
                                input logic v, input logic [1:0] ch);
        vec_t t;
        t.rst = r; t.sel = s; t.scan = sc; t.xm = x; t.ch3 = c3;
        t.d = d; t.v = v; t.ch = ch;
        vecs.push_back(t);
    endfunction

    // Drive one vector before an edge, record its expectation, compare after the edge.
    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk);
        rst           = t.rst;
        sel           = t.sel;
        scan_en       = t.scan;
        xor_mode      = t.xm;
        data_in[31:24] = t.ch3;
        e.d = t.d; e.v = t.v; e.ch = t.ch;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            e = sb.pop_front();
            if (data_out !== e.d || ch_valid !== e.v || ch_out !== e.ch) begin
                errors++;
                $display("FAIL vec%0d: got data=%h valid=%b ch=%0d, want data=%h valid=%b ch=%0d",
                         idx, data_out, ch_valid, ch_out, e.d, e.v, e.ch);
            end
        end
    endtask

    task automatic step5(input logic r, input logic [2:0] s, input logic [7:0] d,
                         input logic v, input logic [2:0] ch, input string name);
        @(negedge clk);
        rst5 = r;
        sel5 = s;
        @(posedge clk);
        #1;
        checks++;
        if (data_out5 !== d || ch_valid5 !== v || ch_out5 !== ch) begin
            errors++;
            $display("FAIL %s: got data=%h valid=%b ch=%0d, want data=%h valid=%b ch=%0d",
                     name, data_out5, ch_valid5, ch_out5, d, v, ch);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = '0; scan_en = 1'b0; xor_mode = 1'b0;
        data_in = {8'h88, 8'h44, 8'h22, 8'h11};
        rst5 = 1'b1; sel5 = '0; scan_en5 = 1'b0; xor_mode5 = 1'b0;
        data_in5 = {8'h55, 8'h88, 8'h44, 8'h22, 8'h11};

        // Reset held 3 clocks, then release
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 8'h88, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h88, 8'h11, 1, 0);
        add(0, 0, 0, 0, 8'h88, 8'h11, 1, 0);
        // Manual switch 0 -> 2: two blank clocks then ch2 data
        add(0, 2, 0, 0, 8'h88, 8'h00, 0, 2);
        add(0, 2, 0, 0, 8'h88, 8'h00, 0, 2);
        add(0, 2, 0, 0, 8'h88, 8'h44, 1, 2);
        add(0, 2, 0, 0, 8'h88, 8'h44, 1, 2);
        // Back to 0, then 1 and 3 one clock apart: blanking restarts
        add(0, 0, 0, 0, 8'h88, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h88, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h88, 8'h11, 1, 0);
        add(0, 1, 0, 0, 8'h88, 8'h00, 0, 1);
        add(0, 3, 0, 0, 8'h88, 8'h00, 0, 3);
        add(0, 3, 0, 0, 8'h88, 8'h00, 0, 3);
        add(0, 3, 0, 0, 8'h88, 8'h88, 1, 3);
        add(0, 0, 0, 0, 8'h88, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h88, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h88, 8'h11, 1, 0);
        // Auto-scan from ch0: change every 8th edge, 2 blank + 6 valid clocks
        for (int i = 1; i <= 34; i++) begin
            int         m;
            int         r;
            logic [1:0] c;
            logic [7:0] val;
            m   = i / 8;
            r   = i % 8;
            c   = 2'(m % 4);
            val = 8'h11 << c;
            if (m == 0)     add(0, 0, 1, 0, 8'h88, 8'h11, 1, 0);
            else if (r < 2) add(0, 0, 1, 0, 8'h88, 8'h00, 0, c);
            else            add(0, 0, 1, 0, 8'h88, val, 1, c);
        end
        add(0, 0, 0, 0, 8'h88, 8'h11, 1, 0);
        // XOR mode, data change, channel change without blanking, then exit
        add(0, 0, 0, 1, 8'h88, 8'hFF, 1, 0);
        add(0, 0, 0, 1, 8'h00, 8'h77, 1, 0);
        add(0, 2, 0, 1, 8'h00, 8'h77, 1, 2);
        add(0, 2, 0, 1, 8'h00, 8'h77, 1, 2);
        add(0, 2, 0, 0, 8'h88, 8'h44, 1, 2);
        // Auto-scan from ch2 into blank, reset mid-blank, scan restarts from count 0
        for (int i = 0; i < 7; i++) add(0, 2, 1, 0, 8'h88, 8'h44, 1, 2);
        add(0, 2, 1, 0, 8'h88, 8'h00, 0, 3);
        add(1, 2, 1, 0, 8'h88, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 2, 1, 0, 8'h88, 8'h11, 1, 0);
        add(0, 2, 1, 0, 8'h88, 8'h00, 0, 1);
        add(0, 2, 1, 0, 8'h88, 8'h00, 0, 1);
        add(0, 2, 1, 0, 8'h88, 8'h22, 1, 1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Out-of-range manual select on the CH=5 instance
        step5(1, 0, 8'h00, 0, 0, "ch5_reset");
        step5(0, 0, 8'h11, 1, 0, "ch5_release");
        step5(0, 5, 8'h11, 1, 0, "ch5_sel5_ignored");
        step5(0, 7, 8'h11, 1, 0, "ch5_sel7_ignored");
        step5(0, 4, 8'h00, 0, 4, "ch5_sel4_blank0");
        step5(0, 4, 8'h00, 0, 4, "ch5_sel4_blank1");
        step5(0, 4, 8'h55, 1, 4, "ch5_sel4_data");
        step5(0, 6, 8'h55, 1, 4, "ch5_sel6_ignored");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
